// File: rtl/audio_pwm_capture_pkg.sv
// Shared audio package: capture FSM states and default widths for the PWM receive path.
package audio_pwm_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNCING = 2'd1,
        ST_MEASURE = 2'd2
    } cap_state_e;

    localparam int AUDIO_SAMPLE_W    = 14;
    localparam int AUDIO_CNT_W       = 16;
    localparam int AUDIO_SYNC_STAGES = 2;

endpackage

// File: rtl/audio_sync_edge.sv
// N-stage synchronizer for an asynchronous level, plus a one-clk pulse on its synchronized rising edge.
module audio_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_rise
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_q    = r_sync[STAGES-1];
    assign o_rise = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/audio_pwm_capture.sv
// PWM audio receiver: counts low clk cycles of pwm_in between frame_clk rising edges and publishes the code.
// Optional PWM_CAPTURE_DEGLITCH_EN adds a 3-tap majority filter on the pwm path (frame path delayed to match).
module audio_pwm_capture
    import audio_pwm_capture_pkg::*;
#(
    parameter int SAMPLE_W    = AUDIO_SAMPLE_W,
    parameter int CNT_W       = AUDIO_CNT_W,
    parameter int SYNC_STAGES = AUDIO_SYNC_STAGES
) (
    input  logic                clk,
    input  logic                RSTn,
    input  logic                frame_clk,
    input  logic                pwm_in,
    input  logic                capture_en,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                overrun,
    output logic                frame_err
);

    logic                w_pwm_sync;
    logic                w_pwm_rise_unused;
    logic                w_frame_rise;
    logic                w_pwm;
    logic                w_edge;
    logic [SAMPLE_W-1:0] w_code;

    cap_state_e          r_state;
    logic [CNT_W-1:0]    r_frame_cnt;
    logic [CNT_W-1:0]    r_low_cnt;
    logic [SAMPLE_W-1:0] r_sample;
    logic                r_valid;
    logic                r_overrun;
    logic                r_frame_err;

    audio_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_frame (
        .clk    (clk),
        .rst_n  (RSTn),
        .i_d    (frame_clk),
        .o_q    (),
        .o_rise (w_frame_rise)
    );

    audio_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_pwm (
        .clk    (clk),
        .rst_n  (RSTn),
        .i_d    (pwm_in),
        .o_q    (w_pwm_sync),
        .o_rise (w_pwm_rise_unused)
    );

`ifdef PWM_CAPTURE_DEGLITCH_EN
    logic [1:0] r_pwm_hist;
    logic       r_edge_dly;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_pwm_hist <= '0;
            r_edge_dly <= 1'b0;
        end else begin
            r_pwm_hist <= {r_pwm_hist[0], w_pwm_sync};
            r_edge_dly <= w_frame_rise;
        end
    end

    // Majority of three consecutive samples behaves as a 1-clk delay for any level lasting >= 2 clks.
    assign w_pwm  = (w_pwm_sync & r_pwm_hist[0]) | (w_pwm_sync & r_pwm_hist[1]) |
                    (r_pwm_hist[0] & r_pwm_hist[1]);
    assign w_edge = r_edge_dly;
`else
    assign w_pwm  = w_pwm_sync;
    assign w_edge = w_frame_rise;
`endif

    // Clamp rather than truncate, so an over-long low time reads as full scale.
    generate
        if (CNT_W > SAMPLE_W) begin : g_sat
            assign w_code = (|r_low_cnt[CNT_W-1:SAMPLE_W]) ? '1 : r_low_cnt[SAMPLE_W-1:0];
        end else begin : g_ext
            assign w_code = SAMPLE_W'(r_low_cnt);
        end
    endgenerate

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_state     <= ST_IDLE;
            r_frame_cnt <= '0;
            r_low_cnt   <= '0;
            r_sample    <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (r_valid && sample_ready)
                r_valid <= 1'b0;

            if (!capture_en) begin
                r_state     <= ST_IDLE;
                r_frame_cnt <= '0;
                r_low_cnt   <= '0;
                r_valid     <= 1'b0;
                r_overrun   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: r_state <= ST_SYNCING;

                    ST_SYNCING: begin
                        if (w_edge) begin
                            r_state     <= ST_MEASURE;
                            r_frame_cnt <= CNT_W'(1);
                            r_low_cnt   <= CNT_W'(!w_pwm);
                        end
                    end

                    ST_MEASURE: begin
                        if (w_edge) begin
                            // A result accepted this very cycle frees the slot for the new one.
                            if (!r_valid || sample_ready) begin
                                r_sample <= w_code;
                                r_valid  <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                            r_frame_cnt <= CNT_W'(1);
                            r_low_cnt   <= CNT_W'(!w_pwm);
                        end else if (&r_frame_cnt) begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_SYNCING;
                            r_frame_cnt <= '0;
                            r_low_cnt   <= '0;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                            if (!w_pwm && !(&r_low_cnt))
                                r_low_cnt <= r_low_cnt + CNT_W'(1);
                        end
                    end

                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign sample_out   = r_sample;
    assign sample_valid = r_valid;
    assign overrun      = r_overrun;
    assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_audio_pwm_capture.sv
// Bench for audio_pwm_capture: directed and random frames checked against a low-time counting model.
module tb_audio_pwm_capture;

    localparam int SAMPLE_W = 14;
    localparam int CODE_MAX = (1 << SAMPLE_W) - 1;
`ifdef PWM_CAPTURE_DEGLITCH_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic                clk = 1'b0;
    logic                RSTn;
    logic                frame_clk, pwm_in, capture_en, sample_ready;
    logic [SAMPLE_W-1:0] sample_out, t_out;
    logic                sample_valid, overrun, frame_err;
    logic                t_valid, t_ovr, t_err;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int got_q[$];
    int t_got_q[$];
    int valid_cycles = 0;
    int err_cnt = 0;
    int t_err_cnt = 0;
    bit have_pend = 1'b0;
    int pend_code = 0;
    int last_pushed = 0;
    int len, low, ng, kind;

    always #5 clk = ~clk;

    audio_pwm_capture dut (
        .clk(clk), .RSTn(RSTn), .frame_clk(frame_clk), .pwm_in(pwm_in), .capture_en(capture_en),
        .sample_out(sample_out), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .overrun(overrun), .frame_err(frame_err)
    );

    // Narrow counters so the frame timeout is reachable in a short run.
    audio_pwm_capture #(.SAMPLE_W(SAMPLE_W), .CNT_W(12), .SYNC_STAGES(2)) dut_t (
        .clk(clk), .RSTn(RSTn), .frame_clk(frame_clk), .pwm_in(pwm_in), .capture_en(capture_en),
        .sample_out(t_out), .sample_valid(t_valid), .sample_ready(sample_ready),
        .overrun(t_ovr), .frame_err(t_err)
    );

    always @(negedge clk) begin
        if (sample_valid && sample_ready) got_q.push_back(int'(sample_out));
        if (t_valid && sample_ready) t_got_q.push_back(int'(t_out));
        if (sample_valid) valid_cycles++;
        if (frame_err) err_cnt++;
        if (t_err) t_err_cnt++;
    end

    function automatic int model_code(input int lo, input int glitches);
        int eff;
        eff = lo;
`ifndef PWM_CAPTURE_DEGLITCH_EN
        eff = lo - glitches;
`endif
        return (eff > CODE_MAX) ? CODE_MAX : eff;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        capture_en = 1'b1;
        frame_clk  = 1'b0;
        pwm_in     = 1'b0;
        repeat (20) tick();
    endtask

    task automatic flush();
        capture_en = 1'b0;
        repeat (3) tick();
        have_pend = 1'b0;
    endtask

    task automatic reset_mid();
        chk("rst_pre_code", sample_out, last_pushed);
        #1 RSTn = 1'b0;
        #1;
        chk("rst_code", sample_out, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_ferr", frame_err, 0);
        #1 RSTn = 1'b1;
        have_pend = 1'b0;
    endtask

    // One frame: rising frame_clk at c=0, line low for the first lo clks, glitches at c=10,20,...
    task automatic frame(input int flen, input int lo, input int glitches, input int rdy_c, input int rst_at);
        int hi;
        hi = (flen >= 16) ? 8 : flen / 2;
        if (have_pend) begin
            exp_q.push_back(pend_code);
            last_pushed = pend_code;
        end
        pend_code = model_code(lo, glitches);
        have_pend = 1'b1;
        for (int c = 0; c < flen; c++) begin
            frame_clk = (c < hi);
            pwm_in    = !(c < lo);
            for (int g = 0; g < glitches; g++)
                if (c == 10 * (g + 1)) pwm_in = 1'b1;
            if (rdy_c >= 0) sample_ready = (c == rdy_c);
            if (c == rst_at) reset_mid();
            tick();
        end
    endtask

    task automatic close_and_check(input string tag);
        if (have_pend) exp_q.push_back(pend_code);
        have_pend = 1'b0;
        frame_clk = 1'b1;
        pwm_in    = 1'b1;
        repeat (8) tick();
        frame_clk = 1'b0;
        repeat (6) tick();
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk(tag, got_q[i], exp_q[i]);
        exp_q.delete();
        got_q.delete();
        flush();
    endtask

    initial begin
        RSTn = 1'b0; capture_en = 1'b0; frame_clk = 1'b0; pwm_in = 1'b1; sample_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_code", sample_out, 0);
        chk("reset_valid", sample_valid, 0);
        chk("reset_ovr", overrun, 0);
        chk("reset_ferr", frame_err, 0);
        chk("reset_t_ovr", t_ovr, 0);
        RSTn = 1'b1;
        tick();

        // steady 300/1024 duty, first partial frame must not appear
        valid_cycles = 0;
        start();
        repeat (4) frame(1024, 300, 0, -1, -1);
        close_and_check("t1_code");
        chk("t1_valid_cycles", valid_cycles, 4);

        // extremes: never low, always low, saturation
        start();
        frame(1024, 0, 0, -1, -1);
        frame(1024, 1024, 0, -1, -1);
        frame(20000, 20000, 0, -1, -1);
        close_and_check("t2_code");

        // single-clk glitches in the low phase
        start();
        frame(1024, 300, 5, -1, -1);
        frame(1024, 300, 5, -1, -1);
        close_and_check("t6_glitch");

        // backpressure: hold, same-cycle accept+load, overrun, flush
        sample_ready = 1'b0;
        start();
        frame(200, 60, 0, -1, -1);
        frame(200, 120, 0, -1, -1);
        chk("t3_hold_valid", sample_valid, 1);
        chk("t3_hold_code", sample_out, 60);
        chk("t3_hold_ovr", overrun, 0);
        frame(200, 90, 0, LAT - 1, -1);
        chk("t3_accept_count", got_q.size(), 1);
        if (got_q.size() > 0) chk("t3_accept_code", got_q[0], 60);
        chk("t3_reload_code", sample_out, 120);
        chk("t3_reload_valid", sample_valid, 1);
        chk("t3_reload_ovr", overrun, 0);
        frame(200, 30, 0, -1, -1);
        chk("t3_ovr_code", sample_out, 120);
        chk("t3_ovr_valid", sample_valid, 1);
        chk("t3_ovr_flag", overrun, 1);
        flush();
        chk("t3_flush_valid", sample_valid, 0);
        chk("t3_flush_ovr", overrun, 0);
        chk("t3_flush_code", sample_out, 120);
        sample_ready = 1'b1;
        exp_q.delete();
        got_q.delete();

        // frame timeout on the narrow-counter instance; wide instance just sees a long frame
        t_got_q.delete();
        t_err_cnt = 0;
        err_cnt   = 0;
        start();
        frame(300, 100, 0, -1, -1);
        frame(4500, 150, 0, -1, -1);
        frame(300, 40, 0, -1, -1);
        frame(300, 70, 0, -1, -1);
        close_and_check("t4_main");
        chk("t4_ferr_pulses", t_err_cnt, 1);
        chk("t4_main_no_ferr", err_cnt, 0);
        chk("t4_t_count", t_got_q.size(), 3);
        if (t_got_q.size() == 3) begin
            chk("t4_t_code0", t_got_q[0], model_code(100, 0));
            chk("t4_t_code1", t_got_q[1], model_code(40, 0));
            chk("t4_t_code2", t_got_q[2], model_code(70, 0));
        end

        // async reset in the middle of a frame
        start();
        frame(600, 300, 0, -1, -1);
        frame(1200, 800, 0, -1, 500);
        frame(600, 200, 0, -1, -1);
        frame(600, 250, 0, -1, -1);
        close_and_check("t5_code");

        // random frames
        start();
        for (int k = 0; k < 12; k++) begin
            len  = int'($urandom_range(700, 16));
            kind = int'($urandom_range(3, 0));
            if (kind == 0)      low = 0;
            else if (kind == 1) low = len;
            else                low = int'($urandom_range(len - 2, 2));
            ng = (low >= 40) ? int'($urandom_range(3, 0)) : 0;
            frame(len, low, ng, -1, -1);
        end
        close_and_check("rand_code");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
